// File: rtl/jtag_pkg.sv
// Shared JTAG definitions used by the TAP controller, IR and decode stages.
//   tap_state_e  : 1149.1 TAP states with their standard 4-bit encodings
//   BYPASS_INST  : instruction code that selects the 1-bit bypass register
//   next_state() : TAP transition function, indexed by current state and TMS
package jtag_pkg;

   typedef enum logic [3:0] {
      ST_EXIT2_DR   = 4'h0,
      ST_EXIT1_DR   = 4'h1,
      ST_SHIFT_DR   = 4'h2,
      ST_PAUSE_DR   = 4'h3,
      ST_SELECT_IR  = 4'h4,
      ST_UPDATE_DR  = 4'h5,
      ST_CAPTURE_DR = 4'h6,
      ST_SELECT_DR  = 4'h7,
      ST_EXIT2_IR   = 4'h8,
      ST_EXIT1_IR   = 4'h9,
      ST_SHIFT_IR   = 4'hA,
      ST_PAUSE_IR   = 4'hB,
      ST_RUN_IDLE   = 4'hC,
      ST_UPDATE_IR  = 4'hD,
      ST_CAPTURE_IR = 4'hE,
      ST_TLR        = 4'hF
   } tap_state_e;

   // All-ones selects bypass, as the standard mandates.
   localparam logic [1:0] BYPASS_INST = 2'b11;

   function automatic tap_state_e next_state(input tap_state_e state, input logic tms);
      tap_state_e nxt;
      nxt = ST_TLR;
      case (state)
         ST_TLR:        nxt = tms ? ST_TLR       : ST_RUN_IDLE;
         ST_RUN_IDLE:   nxt = tms ? ST_SELECT_DR : ST_RUN_IDLE;
         ST_SELECT_DR:  nxt = tms ? ST_SELECT_IR : ST_CAPTURE_DR;
         ST_CAPTURE_DR: nxt = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
         ST_SHIFT_DR:   nxt = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
         ST_EXIT1_DR:   nxt = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
         ST_PAUSE_DR:   nxt = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
         ST_EXIT2_DR:   nxt = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
         ST_UPDATE_DR:  nxt = tms ? ST_SELECT_DR : ST_RUN_IDLE;
         ST_SELECT_IR:  nxt = tms ? ST_TLR       : ST_CAPTURE_IR;
         ST_CAPTURE_IR: nxt = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
         ST_SHIFT_IR:   nxt = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
         ST_EXIT1_IR:   nxt = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
         ST_PAUSE_IR:   nxt = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
         ST_EXIT2_IR:   nxt = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
         ST_UPDATE_IR:  nxt = tms ? ST_SELECT_DR : ST_RUN_IDLE;
         default:       nxt = ST_TLR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: state machine, per-state strobes, 1-bit bypass
// register and registered TDO output mux.
// Ports:
//   TCK                sole clock, rising edge
//   reset              synchronous active-high, forces Test-Logic-Reset
//   TMS, TDI           JTAG mode select / serial data in
//   inst               currently latched instruction (selects bypass)
//   tdo_dr, tdo_ir     serial outputs of the selected DR chain and IR chain
//   test_logic_reset   high while in Test-Logic-Reset
//   capturedr/shiftdr/updatedr/clockdr, captureir/shiftir/updateir
//                      Moore strobes, high for the cycles spent in each state
//   TDO, tdo_en        registered serial out and its valid flag
//   state              current TAP state encoding (debug)
module tap_controller
   import jtag_pkg::*;
#(
   parameter int              IR_W        = 2,
   parameter logic [IR_W-1:0] BYPASS_INST = jtag_pkg::BYPASS_INST
) (
   input  logic            TCK,
   input  logic            reset,
   input  logic            TMS,
   input  logic            TDI,
   input  logic [IR_W-1:0] inst,
   input  logic            tdo_dr,
   input  logic            tdo_ir,
   output logic            test_logic_reset,
   output logic            capturedr,
   output logic            shiftdr,
   output logic            updatedr,
   output logic            clockdr,
   output logic            captureir,
   output logic            shiftir,
   output logic            updateir,
   output logic            TDO,
   output logic            tdo_en,
   output logic [3:0]      state
);

   tap_state_e state_reg;
   logic       bypass_reg;
   logic       tdo_reg;
   logic       tdo_en_reg;
   logic       tdo_next;
   logic       bypass_sel;

   assign bypass_sel = (inst == BYPASS_INST);

   // State register; reset wins over TMS so a scan in progress is simply
   // abandoned without passing through any Update state.
   always_ff @(posedge TCK) begin
      if (reset) begin
         state_reg <= ST_TLR;
      end else begin
         state_reg <= next_state(state_reg, TMS);
      end
   end

   // Strobes are decoded straight from the state register, so each one is
   // high for exactly the cycles spent in its state. The TDO source select
   // is decoded here too since it keys off the same shift states.
   always_comb begin
      test_logic_reset = 1'b0;
      capturedr        = 1'b0;
      shiftdr          = 1'b0;
      updatedr         = 1'b0;
      captureir        = 1'b0;
      shiftir          = 1'b0;
      updateir         = 1'b0;
      case (state_reg)
         ST_TLR:        test_logic_reset = 1'b1;
         ST_CAPTURE_DR: capturedr        = 1'b1;
         ST_SHIFT_DR:   shiftdr          = 1'b1;
         ST_UPDATE_DR:  updatedr         = 1'b1;
         ST_CAPTURE_IR: captureir        = 1'b1;
         ST_SHIFT_IR:   shiftir          = 1'b1;
         ST_UPDATE_IR:  updateir         = 1'b1;
         default:       ;
      endcase
      clockdr = capturedr | shiftdr;

      tdo_next = 1'b0;
      if (shiftir) begin
         tdo_next = tdo_ir;
      end else if (shiftdr) begin
         tdo_next = bypass_sel ? bypass_reg : tdo_dr;
      end
   end

   // Bypass register: captures 0, shifts TDI, and is cleared whenever the
   // TAP sits in Test-Logic-Reset (whether reached by reset or by TMS).
   always_ff @(posedge TCK) begin
      if (reset || state_reg == ST_TLR) begin
         bypass_reg <= 1'b0;
      end else if (bypass_sel && capturedr) begin
         bypass_reg <= 1'b0;
      end else if (bypass_sel && shiftdr) begin
         bypass_reg <= TDI;
      end
   end

   // Output register: TDO and its valid flag lag the shift cycle by one TCK.
   always_ff @(posedge TCK) begin
      if (reset) begin
         tdo_reg    <= 1'b0;
         tdo_en_reg <= 1'b0;
      end else begin
         tdo_reg    <= tdo_next;
         tdo_en_reg <= shiftdr | shiftir;
      end
   end

   assign TDO    = tdo_reg;
   assign tdo_en = tdo_en_reg;
   assign state  = state_reg;

endmodule
